axi_dma_master: RTL and testbench

Burst DMA engine that drives one AXI master port (`inf_Master`, M2AXIout/M2AXIin modports) on behalf of the CNN accelerator's local buffers. A single start command moves `word_cnt` 32-bit words between a base address and a valid/ready word stream. The engine splits the transfer into INCR bursts of at most 16 beats that never cross a 4 KB boundary. It sits between the accelerator's buffer controller and the AXI interconnect master slot.

---
 rtl/axi_dma_master_if.sv | 44 ++++
 rtl/axi_dma_master.sv | 228 ++++++++++++++++++++++
 tb/tb_axi_dma_master.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_master_if.sv
// AXI4 master-side signal bundle used between the DMA engine and the interconnect.
// M2AXIout carries everything the master drives, M2AXIin everything it samples.
interface inf_Master;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport M2AXIout (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        output rready
    );

    modport M2AXIin (
        input awready, wready, bresp, bvalid,
        input arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_dma_master.sv
// Burst DMA engine: moves word_cnt 32-bit words between an AXI address range and a
// valid/ready word stream, in INCR bursts of at most MAX_BEATS that never cross 4 KB.
module axi_dma_master #(
    parameter logic [3:0] AXI_ID    = 4'd0,
    parameter int         MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [31:0]       base_addr,
    input  logic [15:0]       word_cnt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    input  logic [31:0]       wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    inf_Master.M2AXIout       m_out,
    inf_Master.M2AXIin        m_in
);

    localparam logic [15:0] MAX_B = 16'(MAX_BEATS);

    typedef enum logic [2:0] {
        ST_IDLE, ST_AR, ST_R, ST_AW, ST_W, ST_B, ST_DONE
    } state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [15:0] rem_q;
    logic [4:0]  beats_q;
    logic [3:0]  len_q;
    logic [3:0]  beat_q;
    logic        arvalid_q;
    logic        awvalid_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [3:0]  id_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [3:0]  strb_q;

    logic [31:0] burst_end;
    logic [31:0] nxt_addr_d;
    logic [15:0] nxt_rem_d;
    logic [4:0]  nxt_beats_d;
    logic        in_r;
    logic        in_w;

    function automatic logic [4:0] calc_beats(input logic [11:0] offs, input logic [15:0] rem);
        logic [15:0] to_4k;
        logic [15:0] lim;
        to_4k = (16'd4096 - {4'd0, offs}) >> 2;
        lim   = rem;
        if (lim > MAX_B) lim = MAX_B;
        if (lim > to_4k) lim = to_4k;
        return 5'(lim);
    endfunction

    assign burst_end = addr_q + {25'd0, beats_q, 2'b00};

    // Address and remaining count the next burst will be sized from, per state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        nxt_addr_d = burst_end;
        nxt_rem_d  = rem_q - 16'd1;
        case (state_q)
            ST_IDLE: begin
                nxt_addr_d = base_addr & ~32'd3;
                nxt_rem_d  = word_cnt;
            end
            ST_B: begin
                nxt_addr_d = addr_q;
                nxt_rem_d  = rem_q;
            end
            default: ;
        endcase
        nxt_beats_d = calc_beats(nxt_addr_d[11:0], nxt_rem_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            beats_q   <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            id_q      <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            strb_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        addr_q  <= nxt_addr_d;
                        rem_q   <= word_cnt;
                        id_q    <= AXI_ID;
                        size_q  <= 3'b010;
                        burst_q <= 2'b01;
                        strb_q  <= 4'hF;
                        if (word_cnt == 16'd0) begin
                            state_q <= ST_DONE;
                        end else begin
                            beats_q <= nxt_beats_d;
                            len_q   <= 4'(nxt_beats_d - 5'd1);
                            if (rw) begin
                                awvalid_q <= 1'b1;
                                state_q   <= ST_AW;
                            end else begin
                                arvalid_q <= 1'b1;
                                state_q   <= ST_AR;
                            end
                        end
                    end
                end
                ST_AR: begin
                    if (m_in.arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (m_in.rvalid && rd_ready) begin
                        rem_q <= nxt_rem_d;
                        if (m_in.rresp != 2'b00) err_q <= 1'b1;
                        if (m_in.rlast) begin
                            addr_q <= nxt_addr_d;
                            if (rem_q == 16'd1) begin
                                state_q <= ST_DONE;
                            end else begin
                                beats_q   <= nxt_beats_d;
                                len_q     <= 4'(nxt_beats_d - 5'd1);
                                arvalid_q <= 1'b1;
                                state_q   <= ST_AR;
                            end
                        end
                    end
                end
                ST_AW: begin
                    if (m_in.awready) begin
                        awvalid_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= ST_W;
                    end
                end
                ST_W: begin
                    if (wr_valid && m_in.wready) begin
                        rem_q  <= rem_q - 16'd1;
                        beat_q <= beat_q + 4'd1;
                        if (beat_q == len_q) begin
                            addr_q  <= burst_end;
                            state_q <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    if (m_in.bvalid) begin
                        if (m_in.bresp != 2'b00) err_q <= 1'b1;
                        if (rem_q == 16'd0) begin
                            state_q <= ST_DONE;
                        end else begin
                            beats_q   <= nxt_beats_d;
                            len_q     <= 4'(nxt_beats_d - 5'd1);
                            awvalid_q <= 1'b1;
                            state_q   <= ST_AW;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_r = (state_q == ST_R);
    assign in_w = (state_q == ST_W);

    assign m_out.arid    = id_q;
    assign m_out.araddr  = addr_q;
    assign m_out.arlen   = len_q;
    assign m_out.arsize  = size_q;
    assign m_out.arburst = burst_q;
    assign m_out.arvalid = arvalid_q;
    assign m_out.rready  = in_r & rd_ready;

    assign m_out.awid    = id_q;
    assign m_out.awaddr  = addr_q;
    assign m_out.awlen   = len_q;
    assign m_out.awsize  = size_q;
    assign m_out.awburst = burst_q;
    assign m_out.awvalid = awvalid_q;

    // Stream side is a straight pass-through, gated so idle outputs stay at zero.
    assign m_out.wdata  = in_w ? wr_data : '0;
    assign m_out.wstrb  = strb_q;
    assign m_out.wvalid = in_w & wr_valid;
    assign m_out.wlast  = in_w & (beat_q == len_q);
    assign m_out.bready = (state_q == ST_B);

    assign rd_data  = in_r ? m_in.rdata : '0;
    assign rd_valid = in_r & m_in.rvalid;
    assign wr_ready = in_w & m_in.wready;

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_axi_dma_master.sv
// Directed bench for axi_dma_master: a small AXI slave and stream source/sink driven
// on the falling edge, with hand-computed burst layouts and stream contents.
module tb_axi_dma_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rw;
    logic [31:0] base_addr;
    logic [15:0] word_cnt;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;

    inf_Master axi();

    axi_dma_master #(.AXI_ID(4'd0), .MAX_BEATS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw),
        .base_addr(base_addr), .word_cnt(word_cnt),
        .busy(busy), .done(done), .err(err),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .m_out(axi), .m_in(axi)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] bq_addr[$];
    logic [3:0]  bq_len[$];
    int          wlast_at[$];
    int          n_beats;
    int          n_bresp;
    int          done_at;
    int          last_acc;
    logic        err_mid;
    logic        saw_aw;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h5EED_0000;
    endfunction

    function automatic logic [31:0] wr_word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic slave_idle();
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
        axi.rdata = '0; axi.rresp = 2'b00;
        axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
    endtask

    task automatic issue_start(input logic dir, input logic [31:0] a, input logic [15:0] n);
        @(negedge clk);
        rw = dir; base_addr = a; word_cnt = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || err !== 1'b0)
            $display("FAIL start_accept: busy=%b err=%b, required busy=1 err=0", busy, err);
        if (busy !== 1'b1 || err !== 1'b0) tests_failed++;
    endtask

    task automatic run_read(input logic [31:0] a, input logic [15:0] n,
                            input logic [15:0] rv_pat, input logic [15:0] rr_pat);
        int          phase = 0;
        int          bi    = 0;
        logic [3:0]  blen  = '0;
        logic [31:0] baddr = '0;
        bq_addr.delete(); bq_len.delete();
        n_beats = 0; done_at = -100; last_acc = -1; saw_aw = 1'b0;
        issue_start(1'b0, a, n);
        for (int c = 0; c < 600; c++) begin
            slave_idle();
            rd_ready = 1'b0;
            if (done === 1'b1) begin
                done_at = c;
                break;
            end
            if (axi.awvalid === 1'b1) saw_aw = 1'b1;
            if (phase == 0) begin
                if (axi.arvalid === 1'b1) begin
                    bq_addr.push_back(axi.araddr);
                    bq_len.push_back(axi.arlen);
                    baddr = axi.araddr; blen = axi.arlen;
                    axi.arready = 1'b1;
                    phase = 1; bi = 0;
                end
            end else begin
                axi.rvalid = rv_pat[4'(c)];
                rd_ready   = rr_pat[4'(c)];
                axi.rdata  = mem_word(baddr + 32'(bi) * 32'd4);
                axi.rlast  = (bi == int'(blen));
                #1;
                tests_run++;
                if (axi.rready !== rd_ready) begin
                    tests_failed++;
                    $display("FAIL rready_track: rready=%b, required %b", axi.rready, rd_ready);
                end
                if (axi.rvalid && rd_ready) begin
                    tests_run++;
                    if (rd_valid !== 1'b1 || rd_data !== mem_word(a + 32'(n_beats) * 32'd4)) begin
                        tests_failed++;
                        $display("FAIL rd_stream[%0d]: valid=%b data=%h, required valid=1 data=%h",
                                 n_beats, rd_valid, rd_data, mem_word(a + 32'(n_beats) * 32'd4));
                    end
                    n_beats++;
                    if (axi.rlast) begin
                        phase = 0; last_acc = c;
                    end else begin
                        bi++;
                    end
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (done_at < 0) begin
            tests_failed++;
            $display("FAIL read_timeout: done not seen, required a done pulse");
        end
    endtask

    task automatic run_write(input logic [31:0] a, input logic [15:0] n,
                             input logic [15:0] wv_pat, input logic [1:0] first_bresp,
                             input int abort_at);
        int         phase = 0;
        int         bi    = 0;
        logic [3:0] blen  = '0;
        bq_addr.delete(); bq_len.delete(); wlast_at.delete();
        n_beats = 0; n_bresp = 0; done_at = -100; last_acc = -1; err_mid = 1'bx;
        issue_start(1'b1, a, n);
        for (int c = 0; c < 600; c++) begin
            slave_idle();
            wr_valid = 1'b0; wr_data = '0;
            if (done === 1'b1) begin
                done_at = c;
                break;
            end
            if (phase == 0) begin
                if (axi.awvalid === 1'b1) begin
                    bq_addr.push_back(axi.awaddr);
                    bq_len.push_back(axi.awlen);
                    if (bq_addr.size() == 2) err_mid = err;
                    blen = axi.awlen;
                    axi.awready = 1'b1;
                    phase = 1; bi = 0;
                end
            end else if (phase == 1) begin
                axi.wready = 1'b1;
                if (abort_at > 0 && n_beats == abort_at) begin
                    wr_valid = 1'b1;
                    rd_ready = 1'b1;
                    rst = 1'b1;
                    #1;
                    tests_run++;
                    if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.wlast, axi.bready,
                         axi.rready, wr_ready, busy} !== 8'b0) begin
                        tests_failed++;
                        $display("FAIL reset_mid_w: ar/aw/w/wlast/b/r/wr_ready/busy=%b, required 00000000",
                                 {axi.arvalid, axi.awvalid, axi.wvalid, axi.wlast, axi.bready,
                                  axi.rready, wr_ready, busy});
                    end
                    @(negedge clk);
                    rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
                    return;
                end
                wr_valid = wv_pat[4'(c)];
                wr_data  = wr_word(n_beats);
                #1;
                tests_run++;
                if (axi.wvalid !== wr_valid) begin
                    tests_failed++;
                    $display("FAIL wvalid_track: wvalid=%b, required %b", axi.wvalid, wr_valid);
                end
                if (wr_valid) begin
                    tests_run++;
                    if (axi.wdata !== wr_word(n_beats) || wr_ready !== 1'b1 ||
                        axi.wlast !== (bi == int'(blen))) begin
                        tests_failed++;
                        $display("FAIL w_beat[%0d]: wdata=%h wr_ready=%b wlast=%b, required %h 1 %b",
                                 n_beats, axi.wdata, wr_ready, axi.wlast, wr_word(n_beats), bi == int'(blen));
                    end
                    if (axi.wlast === 1'b1) wlast_at.push_back(n_beats + 1);
                    n_beats++;
                    if (bi == int'(blen)) phase = 2;
                    else bi++;
                end
            end else begin
                axi.bvalid = 1'b1;
                axi.bresp  = (n_bresp == 0) ? first_bresp : 2'b00;
                #1;
                tests_run++;
                if (axi.bready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL bready: bready=%b, required 1", axi.bready);
                end
                n_bresp++;
                phase = 0; last_acc = c;
            end
            @(negedge clk);
        end
        tests_run++;
        if (done_at < 0) begin
            tests_failed++;
            $display("FAIL write_timeout: done not seen, required a done pulse");
        end
    endtask

    task automatic check_bursts(input string tag, input int nexp,
                                input logic [31:0] ea0, input logic [3:0] el0,
                                input logic [31:0] ea1, input logic [3:0] el1);
        logic [31:0] ea[2];
        logic [3:0]  el[2];
        ea[0] = ea0; ea[1] = ea1; el[0] = el0; el[1] = el1;
        tests_run++;
        if (bq_addr.size() != nexp) begin
            tests_failed++;
            $display("FAIL %s_burst_count: %0d bursts, required %0d", tag, bq_addr.size(), nexp);
        end else begin
            for (int i = 0; i < nexp; i++) begin
                tests_run++;
                if (bq_addr[i] !== ea[i] || bq_len[i] !== el[i]) begin
                    tests_failed++;
                    $display("FAIL %s_burst[%0d]: addr=%h len=%0d, required addr=%h len=%0d",
                             tag, i, bq_addr[i], bq_len[i], ea[i], el[i]);
                end
            end
        end
    endtask

    task automatic check_finish(input string tag, input int nexp_beats, input logic exp_err);
        tests_run++;
        if (n_beats != nexp_beats || done_at != last_acc + 2 || err !== exp_err) begin
            tests_failed++;
            $display("FAIL %s_finish: beats=%0d done_at=%0d last_acc=%0d err=%b, required beats=%0d done_at=last_acc+2 err=%b",
                     tag, n_beats, done_at, last_acc, err, nexp_beats, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rw = 1'b0; base_addr = '0; word_cnt = '0;
        slave_idle();
        axi.wready = 1'b1; axi.rvalid = 1'b1;
        rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, axi.wlast} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_valids: %b, required 000000",
                     {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, axi.wlast});
        end
        tests_run++;
        if ({axi.araddr, axi.awaddr, axi.wdata} !== 96'b0) begin
            tests_failed++;
            $display("FAIL reset_addr_data: araddr=%h awaddr=%h wdata=%h, required 0",
                     axi.araddr, axi.awaddr, axi.wdata);
        end
        tests_run++;
        if ({axi.arlen, axi.awlen, axi.arsize, axi.awsize, axi.arburst, axi.awburst,
             axi.wstrb, axi.arid, axi.awid} !== 30'b0) begin
            tests_failed++;
            $display("FAIL reset_fields: len/size/burst/strb/id not all 0");
        end
        tests_run++;
        if ({busy, done, err, wr_ready, rd_valid} !== 5'b0 || rd_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_status: busy/done/err/wr_ready/rd_valid=%b rd_data=%h, required 0",
                     {busy, done, err, wr_ready, rd_valid}, rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        slave_idle(); rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
        @(negedge clk);
        tests_run++;
        if ({busy, done, axi.arvalid, axi.awvalid} !== 4'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: busy/done/arvalid/awvalid=%b, required 0000",
                     {busy, done, axi.arvalid, axi.awvalid});
        end
    endtask

    task automatic test_read_20();
        run_read(32'h0000_1000, 16'd20, 16'hFFFF, 16'hFFFF);
        check_bursts("rd20", 2, 32'h1000, 4'd15, 32'h1040, 4'd3);
        check_finish("rd20", 20, 1'b0);
    endtask

    task automatic test_write_5();
        run_write(32'h0000_0FF8, 16'd5, 16'hFFFF, 2'b00, 0);
        check_bursts("wr5", 2, 32'h0FF8, 4'd1, 32'h1000, 4'd2);
        check_finish("wr5", 5, 1'b0);
        tests_run++;
        if (wlast_at.size() != 2 || n_bresp != 2) begin
            tests_failed++;
            $display("FAIL wr5_wlast_b: wlast_count=%0d bresp_count=%0d, required 2 and 2",
                     wlast_at.size(), n_bresp);
        end else begin
            tests_run++;
            if (wlast_at[0] != 2 || wlast_at[1] != 5) begin
                tests_failed++;
                $display("FAIL wr5_wlast_pos: beats %0d,%0d, required 2,5", wlast_at[0], wlast_at[1]);
            end
        end
    endtask

    task automatic test_read_gaps();
        run_read(32'h0000_2000, 16'd16, 16'b1011_0110_1101_1011, 16'b1101_1011_0111_0110);
        check_bursts("rdgap", 1, 32'h2000, 4'd15, 32'h0, 4'd0);
        tests_run++;
        if (n_beats != 16 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rdgap_finish: beats=%0d err=%b, required 16 and 0", n_beats, err);
        end
    endtask

    task automatic test_zero_count();
        run_read(32'h0000_3000, 16'd0, 16'hFFFF, 16'hFFFF);
        tests_run++;
        if (bq_addr.size() != 0 || saw_aw !== 1'b0 || done_at != 1) begin
            tests_failed++;
            $display("FAIL zero_count: arvalid_bursts=%0d awvalid_seen=%b done_at=%0d, required 0 0 1",
                     bq_addr.size(), saw_aw, done_at);
        end
    endtask

    task automatic test_write_err();
        run_write(32'h0000_0000, 16'd32, 16'b1110_1111_0111_1101, 2'b10, 0);
        check_bursts("wrerr", 2, 32'h0000, 4'd15, 32'h0040, 4'd15);
        check_finish("wrerr", 32, 1'b1);
        tests_run++;
        if (err_mid !== 1'b1 || n_bresp != 2) begin
            tests_failed++;
            $display("FAIL wrerr_sticky: err_at_2nd_aw=%b bresp_count=%0d, required 1 and 2",
                     err_mid, n_bresp);
        end
        run_read(32'h0000_0300, 16'd3, 16'hFFFF, 16'hFFFF);
        check_bursts("errclr", 1, 32'h0300, 4'd2, 32'h0, 4'd0);
        check_finish("errclr", 3, 1'b0);
    endtask

    task automatic test_reset_mid_w();
        run_write(32'h0000_0500, 16'd32, 16'hFFFF, 2'b00, 5);
        run_read(32'h0000_0600, 16'd4, 16'hFFFF, 16'hFFFF);
        check_bursts("postrst", 1, 32'h0600, 4'd3, 32'h0, 4'd0);
        check_finish("postrst", 4, 1'b0);
    endtask

    initial begin
        test_reset();
        test_read_20();
        test_write_5();
        test_read_gaps();
        test_zero_count();
        test_write_err();
        test_reset_mid_w();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
